// File: rtl/rv32i_types.sv
// Shared pipeline types for the RV32I core; holds the hazard-control FSM encoding.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN,
    IWAIT,
    IWAIT_KILL,
    DWAIT
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc and holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stalls, bubbles, redirect flushes and stale-fetch kill.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_load,
  output logic             id_ex_flush,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      perf_dstall,
  output logic [31:0]      perf_istall,
  output logic [31:0]      perf_lu_bubble,
  output logic [31:0]      perf_flush,
`endif
  output logic             fetch_kill
);

  hazard_state_t state_q, state_d;

  logic dwait, iwait, load_use, outstanding, kill_pending;

  assign dwait        = dmem_req & ~dmem_resp;
  assign iwait        = imem_req & ~imem_resp;
  assign kill_pending = (state_q == IWAIT_KILL);
  // A fetch is in flight if it is stalling now or was still pending last cycle.
  assign outstanding  = iwait | ((state_q == IWAIT) & ~imem_resp);
  assign load_use     = ex_mem_read & (ex_rd != '0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = RUN;
    if (dwait) begin
      // Keep a pending kill alive across a data stall.
      state_d = kill_pending ? IWAIT_KILL : DWAIT;
    end else if (ex_redirect) begin
      if (kill_pending) begin
        state_d = imem_resp ? RUN : IWAIT_KILL;
      end else begin
        state_d = outstanding ? IWAIT_KILL : RUN;
      end
    end else if (kill_pending) begin
      state_d = imem_resp ? RUN : IWAIT_KILL;
    end else if (iwait) begin
      state_d = IWAIT;
    end
  end

  always_comb begin
    pc_load     = 1'b0;
    if_id_load  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_load  = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_load = 1'b0;
    mem_wb_load = 1'b0;
    fetch_kill  = 1'b0;
    if (!rst || dwait) begin
      // frozen: every enable stays low
    end else if (ex_redirect) begin
      pc_load     = 1'b1;
      if_id_load  = 1'b1;
      if_id_flush = 1'b1;
      id_ex_load  = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
      fetch_kill  = kill_pending & imem_resp;
    end else if (kill_pending || iwait) begin
      // Fetch bubble; the stale instruction is dropped when it returns.
      if_id_load  = 1'b1;
      if_id_flush = 1'b1;
      id_ex_load  = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
      fetch_kill  = kill_pending & imem_resp;
    end else if (load_use) begin
      id_ex_load  = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end else begin
      pc_load     = 1'b1;
      if_id_load  = 1'b1;
      id_ex_load  = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic dstall_ev, istall_ev, lu_ev, flush_ev;

  assign dstall_ev = rst & dwait;
  assign flush_ev  = rst & ~dwait & ex_redirect;
  assign istall_ev = rst & ~dwait & ~ex_redirect &
                     ((kill_pending & ~imem_resp) | (~kill_pending & iwait));
  assign lu_ev     = rst & ~dwait & ~ex_redirect & ~kill_pending & ~iwait & load_use;

  sat_counter #(.W(32)) u_cnt_dstall (.clk(clk), .rst(rst), .inc(dstall_ev), .count(perf_dstall));
  sat_counter #(.W(32)) u_cnt_istall (.clk(clk), .rst(rst), .inc(istall_ev), .count(perf_istall));
  sat_counter #(.W(32)) u_cnt_lu     (.clk(clk), .rst(rst), .inc(lu_ev),     .count(perf_lu_bubble));
  sat_counter #(.W(32)) u_cnt_flush  (.clk(clk), .rst(rst), .inc(flush_ev),  .count(perf_flush));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; perf counters are checked when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;
  import rv32i_types::*;

  localparam int REG_W = 5;

  // {pc, if_id, if_id_flush, id_ex, id_ex_flush, ex_mem, mem_wb, fetch_kill}
  localparam logic [7:0] O_ZERO = 8'b0000_0000;
  localparam logic [7:0] O_NORM = 8'b1101_0110;
  localparam logic [7:0] O_LU   = 8'b0001_1110;
  localparam logic [7:0] O_IW   = 8'b0111_0110;
  localparam logic [7:0] O_RED  = 8'b1111_1110;
  localparam logic [7:0] O_KILL = 8'b0111_0111;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic imem_req, imem_resp, dmem_req, dmem_resp;
  logic pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush;
  logic ex_mem_load, mem_wb_load, fetch_kill;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_dstall, perf_istall, perf_lu_bubble, perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_load(pc_load), .if_id_load(if_id_load), .if_id_flush(if_id_flush),
    .id_ex_load(id_ex_load), .id_ex_flush(id_ex_flush),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
`ifdef HAZARD_PERF_EN
    .perf_dstall(perf_dstall), .perf_istall(perf_istall),
    .perf_lu_bubble(perf_lu_bubble), .perf_flush(perf_flush),
`endif
    .fetch_kill(fetch_kill)
  );

  logic [7:0] outs;
  assign outs = {pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
                 ex_mem_load, mem_wb_load, fetch_kill};

  // Quiet inputs: imem returns immediately, no dmem access, no hazards.
  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_redirect = 1'b0;
    imem_req = 1'b1; imem_resp = 1'b1;
    dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    ex_redirect = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    step(); #1;
    checks++;
    if (outs !== O_ZERO) begin
      errors++; $display("FAIL reset_outs got %b want %b", outs, O_ZERO);
    end
    checks++;
    if (dut.state_q !== RUN) begin
      errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, RUN);
    end
    idle();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_NORM) begin
      errors++; $display("FAIL reset_release got %b want %b", outs, O_NORM);
    end
  endtask

  task automatic test_load_use();
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL lu_rs1 got %b want %b", outs, O_LU);
    end
    step();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1;
    checks++;
    if (outs !== O_NORM) begin
      errors++; $display("FAIL lu_after got %b want %b", outs, O_NORM);
    end
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd1; id_rs2 = 5'd9;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL lu_rs2 got %b want %b", outs, O_LU);
    end
    step();
    id_uses_rs2 = 1'b0;
    #1;
    checks++;
    if (outs !== O_NORM) begin
      errors++; $display("FAIL lu_unused_rs2 got %b want %b", outs, O_NORM);
    end
    step();
    ex_mem_read = 1'b0; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (outs !== O_NORM) begin
      errors++; $display("FAIL lu_not_load got %b want %b", outs, O_NORM);
    end
    step();
    idle();
  endtask

  task automatic test_x0();
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (outs !== O_NORM) begin
      errors++; $display("FAIL x0_no_stall got %b want %b", outs, O_NORM);
    end
    step();
    idle();
  endtask

  task automatic test_imem_wait();
    step();
    imem_req = 1'b1; imem_resp = 1'b0;
    #1;
    checks++;
    if (outs !== O_IW) begin
      errors++; $display("FAIL iwait_1 got %b want %b", outs, O_IW);
    end
    step();
    #1;
    checks++;
    if (dut.state_q !== IWAIT) begin
      errors++; $display("FAIL iwait_state got %0d want %0d", dut.state_q, IWAIT);
    end
    step();
    imem_resp = 1'b1;
    #1;
    checks++;
    if (outs !== O_NORM) begin
      errors++; $display("FAIL iwait_resp got %b want %b", outs, O_NORM);
    end
    step();
    idle();
  endtask

  task automatic test_dwait_redirect();
    for (int i = 0; i < 3; i++) begin
      step();
      dmem_req = 1'b1; dmem_resp = 1'b0; ex_redirect = 1'b1;
      #1;
      checks++;
      if (outs !== O_ZERO) begin
        errors++; $display("FAIL dwait_cyc%0d got %b want %b", i, outs, O_ZERO);
      end
    end
    step();
    dmem_resp = 1'b1;
    #1;
    checks++;
    if (outs !== O_RED) begin
      errors++; $display("FAIL dwait_resp_redirect got %b want %b", outs, O_RED);
    end
    step();
    idle();
    #1;
    checks++;
    if (outs !== O_NORM || dut.state_q !== RUN) begin
      errors++; $display("FAIL dwait_after got %b/%0d want %b/%0d", outs, dut.state_q, O_NORM, RUN);
    end
  endtask

  task automatic test_redirect_kill();
    step();
    imem_req = 1'b1; imem_resp = 1'b0; ex_redirect = 1'b1;
    #1;
    checks++;
    if (outs !== O_RED) begin
      errors++; $display("FAIL rk_redirect got %b want %b", outs, O_RED);
    end
    step();
    ex_redirect = 1'b0;
    #1;
    checks++;
    if (outs !== O_IW || dut.state_q !== IWAIT_KILL) begin
      errors++; $display("FAIL rk_wait got %b/%0d want %b/%0d", outs, dut.state_q, O_IW, IWAIT_KILL);
    end
    step();
    imem_resp = 1'b1;
    #1;
    checks++;
    if (outs !== O_KILL) begin
      errors++; $display("FAIL rk_kill got %b want %b", outs, O_KILL);
    end
    step();
    #1;
    checks++;
    if (outs !== O_NORM || dut.state_q !== RUN) begin
      errors++; $display("FAIL rk_after got %b/%0d want %b/%0d", outs, dut.state_q, O_NORM, RUN);
    end
    // second redirect while a kill is pending keeps the single kill pending
    step();
    imem_resp = 1'b0; ex_redirect = 1'b1;
    step();
    #1;
    checks++;
    if (outs !== O_RED || dut.state_q !== IWAIT_KILL) begin
      errors++; $display("FAIL rk_second got %b/%0d want %b/%0d", outs, dut.state_q, O_RED, IWAIT_KILL);
    end
    step();
    ex_redirect = 1'b0; imem_resp = 1'b1;
    #1;
    checks++;
    if (outs !== O_KILL) begin
      errors++; $display("FAIL rk_second_kill got %b want %b", outs, O_KILL);
    end
    step();
    #1;
    checks++;
    if (fetch_kill !== 1'b0) begin
      errors++; $display("FAIL rk_single_kill got %b want 0", fetch_kill);
    end
    idle();
  endtask

  task automatic test_reset_mid_dwait();
    step();
    dmem_req = 1'b1; dmem_resp = 1'b0;
    step();
    #1;
    checks++;
    if (dut.state_q !== DWAIT) begin
      errors++; $display("FAIL rd_state got %0d want %0d", dut.state_q, DWAIT);
    end
    #1;
    rst = 1'b0;
    dmem_req = 1'b0;
    #1;
    checks++;
    if (outs !== O_ZERO || dut.state_q !== RUN) begin
      errors++; $display("FAIL rd_async got %b/%0d want %b/%0d", outs, dut.state_q, O_ZERO, RUN);
    end
    step();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_NORM || dut.state_q !== RUN) begin
      errors++; $display("FAIL rd_release got %b/%0d want %b/%0d", outs, dut.state_q, O_NORM, RUN);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++;
    if (perf_dstall !== 32'd0 || perf_lu_bubble !== 32'd0) begin
      errors++; $display("FAIL perf_clear got %0d/%0d want 0/0", perf_dstall, perf_lu_bubble);
    end
    dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) step();
    dmem_req = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    step();
    idle();
    step();
    #1;
    checks++;
    if (perf_dstall !== 32'd4) begin
      errors++; $display("FAIL perf_dstall got %0d want 4", perf_dstall);
    end
    checks++;
    if (perf_lu_bubble !== 32'd1) begin
      errors++; $display("FAIL perf_lu_bubble got %0d want 1", perf_lu_bubble);
    end
    checks++;
    if (perf_istall !== 32'd0 || perf_flush !== 32'd0) begin
      errors++; $display("FAIL perf_other got %0d/%0d want 0/0", perf_istall, perf_flush);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_imem_wait();
    test_dwait_redirect();
    test_redirect_kill();
    test_reset_mid_dwait();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
